// File: rtl/dht11_report_ctrl.sv
// dht11_report_ctrl: turns checksum-valid DHT11 measurements into 15-byte
// ASCII report lines ("T:dd.dd H:dd%\r\n") and streams them to a UART TX
// over a valid/ready handshake.
//
// Optional feature macro: DHT11_ERR_REPORT_EN
//   When defined, a sensor-silence timer emits "ERR\r\n" frames after
//   TIMEOUT_CYCLES cycles without a new sample. When undefined, only sample
//   frames are produced and no timer logic exists.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no frame in flight; picks up pend (first) or err_pend
// ST_SEND  | presenting frame byte idx, waiting for tx_data_ready

module dht11_report_ctrl #(
  parameter int          CLK_FRE        = 50,
  parameter int          REPORT_DIV     = 1,
  parameter int unsigned TIMEOUT_CYCLES = CLK_FRE * 1000000 * 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  dht11_state,
  input  logic [23:0] data_rec,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [7:0] DIV_LAST     = 8'(REPORT_DIV - 1);
  localparam logic [3:0] LAST_SAMPLE  = 4'd14;
  localparam logic [3:0] LAST_ERR     = 4'd4;

  state_t      state, state_nxt;
  logic [3:0]  prev_state;
  logic        new_sample;
  logic        reportable;
  logic [7:0]  div_cnt;
  logic        pend;
  logic [23:0] pend_data;
  logic        err_pend;
  logic        take_pend;

  logic [23:0] frame_data, frame_data_nxt;
  logic        frame_err, frame_err_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [3:0]  idx_last;
  logic [7:0]  tx_data_nxt;
  logic        tx_valid_nxt;
  logic [15:0] frame_cnt_nxt;

  // ASCII digit for a BCD nibble; anything outside 0..9 is shown as '?'
  function automatic logic [7:0] digit(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 + {4'h0, n};
    else           return 8'h3F;
  endfunction

  // Byte i of a frame, for either the sample line or the ERR line
  function automatic logic [7:0] frame_byte(input logic [23:0] d,
                                            input logic        err,
                                            input logic [3:0]  i);
    logic [7:0] b;
    b = 8'h0A;
    if (err) begin
      case (i)
        4'd0:    b = 8'h45;
        4'd1:    b = 8'h52;
        4'd2:    b = 8'h52;
        4'd3:    b = 8'h0D;
        default: b = 8'h0A;
      endcase
    end else begin
      case (i)
        4'd0:    b = 8'h54;
        4'd1:    b = 8'h3A;
        4'd2:    b = digit(d[23:20]);
        4'd3:    b = digit(d[19:16]);
        4'd4:    b = 8'h2E;
        4'd5:    b = digit(d[15:12]);
        4'd6:    b = digit(d[11:8]);
        4'd7:    b = 8'h20;
        4'd8:    b = 8'h48;
        4'd9:    b = 8'h3A;
        4'd10:   b = digit(d[7:4]);
        4'd11:   b = digit(d[3:0]);
        4'd12:   b = 8'h25;
        4'd13:   b = 8'h0D;
        default: b = 8'h0A;
      endcase
    end
    return b;
  endfunction

  assign new_sample = (dht11_state == 4'd1) && (prev_state == 4'd9);
  assign reportable = new_sample && (div_cnt == DIV_LAST);
  assign take_pend  = (state == ST_IDLE) && pend;
  assign busy       = (state != ST_IDLE);
  assign idx_last   = frame_err ? LAST_ERR : LAST_SAMPLE;

  // Edge detector on the reader state: completed measurement is 9 -> 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_state <= 4'd0;
    else        prev_state <= dht11_state;
  end

  // Report divider: only every REPORT_DIV-th sample is reportable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= 8'd0;
    end else if (new_sample) begin
      if (div_cnt == DIV_LAST) div_cnt <= 8'd0;
      else                     div_cnt <= div_cnt + 8'd1;
    end
  end

  // One-deep pending buffer; a load in the same cycle IDLE consumes it wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_data <= 24'd0;
      drop_cnt  <= 8'd0;
    end else if (reportable) begin
      pend      <= 1'b1;
      pend_data <= data_rec;
      if (pend && !take_pend && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end else if (take_pend) begin
      pend <= 1'b0;
    end
  end

`ifdef DHT11_ERR_REPORT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] timer;
  logic        timeout_hit;
  logic        take_err;

  assign timeout_hit = !new_sample && (timer == TIMEOUT_LAST);
  assign take_err    = (state == ST_IDLE) && !pend && err_pend;

  // Silence timer: any sample (reportable or not) restarts the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           timer <= 32'd0;
    else if (new_sample)  timer <= 32'd0;
    else if (timeout_hit) timer <= 32'd0;
    else                  timer <= timer + 32'd1;
  end

  // Timeout flag; a repeat timeout while already pending is absorbed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           err_pend <= 1'b0;
    else if (timeout_hit) err_pend <= 1'b1;
    else if (take_err)    err_pend <= 1'b0;
  end
`else
  assign err_pend = 1'b0;
`endif

  // FSM and frame datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      frame_data    <= 24'd0;
      frame_err     <= 1'b0;
      idx           <= 4'd0;
      tx_data       <= 8'h00;
      tx_data_valid <= 1'b0;
      frame_cnt     <= 16'd0;
    end else begin
      state         <= state_nxt;
      frame_data    <= frame_data_nxt;
      frame_err     <= frame_err_nxt;
      idx           <= idx_nxt;
      tx_data       <= tx_data_nxt;
      tx_data_valid <= tx_valid_nxt;
      frame_cnt     <= frame_cnt_nxt;
    end
  end

  // Next-state logic: start frames from IDLE, step bytes on each accept
  always_comb begin
    state_nxt      = state;
    frame_data_nxt = frame_data;
    frame_err_nxt  = frame_err;
    idx_nxt        = idx;
    tx_data_nxt    = tx_data;
    tx_valid_nxt   = tx_data_valid;
    frame_cnt_nxt  = frame_cnt;
    case (state)
      ST_IDLE: begin
        if (pend) begin
          frame_data_nxt = pend_data;
          frame_err_nxt  = 1'b0;
          idx_nxt        = 4'd0;
          tx_data_nxt    = frame_byte(pend_data, 1'b0, 4'd0);
          tx_valid_nxt   = 1'b1;
          state_nxt      = ST_SEND;
        end else if (err_pend) begin
          frame_err_nxt  = 1'b1;
          idx_nxt        = 4'd0;
          tx_data_nxt    = frame_byte(frame_data, 1'b1, 4'd0);
          tx_valid_nxt   = 1'b1;
          state_nxt      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_data_ready) begin
          if (idx != idx_last) begin
            idx_nxt     = idx + 4'd1;
            tx_data_nxt = frame_byte(frame_data, frame_err, idx + 4'd1);
          end else begin
            tx_valid_nxt  = 1'b0;
            frame_cnt_nxt = frame_cnt + 16'd1;
            state_nxt     = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dht11_report_ctrl.sv
// Self-checking bench for dht11_report_ctrl (REPORT_DIV=3, TIMEOUT_CYCLES=100).
module tb_dht11_report_ctrl;

  localparam int DIV = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  dht11_state = 4'd0;
  logic [23:0] data_rec = 24'd0;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;
  int div_m = 0;
  int frames_m = 0;
  int rdy_mode = 0;
  int rdy_ph = 0;
  int cyc = 0;
  logic [7:0] rx_q[$];
  int e_cyc_q[$];
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  dht11_report_ctrl #(
    .CLK_FRE(50),
    .REPORT_DIV(DIV),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dht11_state(dht11_state),
    .data_rec(data_rec),
    .tx_data(tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready),
    .busy(busy),
    .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ready pattern: 0 always, 1 one-of-three, 2 random, 3 never
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tx_data_ready = 1'b1;
        1: begin tx_data_ready = (rdy_ph == 0); rdy_ph = (rdy_ph + 1) % 3; end
        2: tx_data_ready = 1'($urandom_range(0, 1));
        default: tx_data_ready = 1'b0;
      endcase
    end
  end

  // byte collector and stall-stability watcher
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (tx_data_valid !== 1'b1 || tx_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", tx_data_valid, tx_data, prev_data);
        end
      end
      if (tx_data_valid === 1'b1 && tx_data_ready === 1'b1) begin
        rx_q.push_back(tx_data);
        if (tx_data == 8'h45) e_cyc_q.push_back(cyc);
      end
      prev_stall = (tx_data_valid === 1'b1) && (tx_data_ready !== 1'b1);
      prev_data  = tx_data;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // reference: ASCII line for a BCD snapshot
  function automatic logic [7:0] dig(input logic [3:0] n);
    return (n <= 4'd9) ? (8'd48 + 8'(n)) : 8'h3F;
  endfunction

  function automatic logic [7:0] exp_sample(input logic [23:0] d, input int i);
    logic [7:0] s [15];
    s = '{8'h54, 8'h3A, dig(d[23:20]), dig(d[19:16]), 8'h2E, dig(d[15:12]), dig(d[11:8]),
          8'h20, 8'h48, 8'h3A, dig(d[7:4]), dig(d[3:0]), 8'h25, 8'h0D, 8'h0A};
    return s[i];
  endfunction

  function automatic logic [7:0] exp_err(input int i);
    logic [7:0] s [5];
    s = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
    return s[i];
  endfunction

  // one 9 -> 1 transition; called and returns at posedge+1
  task automatic inject(input logic [23:0] d, output bit rep);
    dht11_state = 4'd9;
    @(posedge clk); #1;
    dht11_state = 4'd1;
    data_rec = d;
    @(posedge clk); #1;
    dht11_state = 4'd2;
    data_rec = 24'($urandom);
    rep = (div_m == DIV - 1);
    div_m = rep ? 0 : div_m + 1;
  endtask

  // inject filler samples until the next one is reportable, then inject d
  task automatic report(input logic [23:0] d);
    bit r;
    while (div_m != DIV - 1) inject(24'($urandom), r);
    inject(d, r);
  endtask

  task automatic wait_bytes(input int n);
    int b;
    b = 3000;
    while (rx_q.size() < n && b > 0) begin
      @(posedge clk); #1;
      b--;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks += 5;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", tx_data_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit r;
    logic [7:0] b;
    logic [23:0] d;
    d = 24'h235045;
    rdy_mode = 0;
    while (div_m != DIV - 1) inject(24'($urandom), r);
    inject(d, r);
    checks++;
    if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_e0: valid=%b expected 0", tx_data_valid); end
    @(posedge clk); #1;
    checks++;
    if (tx_data_valid !== 1'b1 || tx_data !== 8'h54) begin
      errors++; $display("FAIL basic_latency_e1: valid=%b data=%h expected valid=1 data=54", tx_data_valid, tx_data);
    end
    wait_bytes(15);
    frames_m++;
    checks++;
    if (rx_q.size() < 15) begin
      errors++; $display("FAIL basic_timeout: got %0d bytes expected 15", rx_q.size());
    end else begin
      for (int i = 0; i < 15; i++) begin
        b = rx_q.pop_front();
        checks++;
        if (b !== exp_sample(d, i)) begin errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, b, exp_sample(d, i)); end
      end
    end
    @(posedge clk); #1;
    checks += 2;
    if (frame_cnt !== 16'(frames_m)) begin errors++; $display("FAIL basic_frame_cnt: got %0d expected %0d", frame_cnt, frames_m); end
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy); end
  endtask

  task automatic test_divider();
    bit r;
    logic [7:0] b;
    logic [23:0] d;
    d = 24'hA00000;
    rdy_mode = 0;
    inject(d, r);
    inject(d, r);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rx_q.size() != 0 || tx_data_valid !== 1'b0) begin
      errors++; $display("FAIL div_early_frame: bytes=%0d valid=%b expected 0 and 0", rx_q.size(), tx_data_valid);
    end
    inject(d, r);
    wait_bytes(15);
    frames_m++;
    checks++;
    if (rx_q.size() < 15) begin
      errors++; $display("FAIL div_timeout: got %0d bytes expected 15", rx_q.size());
    end else begin
      for (int i = 0; i < 15; i++) begin
        b = rx_q.pop_front();
        checks++;
        if (b !== exp_sample(d, i)) begin errors++; $display("FAIL div_byte%0d: got %h expected %h", i, b, exp_sample(d, i)); end
      end
    end
    repeat (20) @(posedge clk);
    #1;
    checks += 2;
    if (rx_q.size() != 0) begin errors++; $display("FAIL div_extra_bytes: got %0d expected 0", rx_q.size()); end
    if (frame_cnt !== 16'(frames_m)) begin errors++; $display("FAIL div_frame_cnt: got %0d expected %0d", frame_cnt, frames_m); end
  endtask

  task automatic test_backpressure();
    logic [7:0] b;
    logic [23:0] d;
    d = 24'h235045;
    rdy_mode = 1;
    report(d);
    wait_bytes(15);
    frames_m++;
    checks++;
    if (rx_q.size() < 15) begin
      errors++; $display("FAIL bp_timeout: got %0d bytes expected 15", rx_q.size());
    end else begin
      for (int i = 0; i < 15; i++) begin
        b = rx_q.pop_front();
        checks++;
        if (b !== exp_sample(d, i)) begin errors++; $display("FAIL bp_byte%0d: got %h expected %h", i, b, exp_sample(d, i)); end
      end
    end
    rdy_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    checks += 2;
    if (rx_q.size() != 0) begin errors++; $display("FAIL bp_extra_bytes: got %0d expected 0", rx_q.size()); end
    if (frame_cnt !== 16'(frames_m)) begin errors++; $display("FAIL bp_frame_cnt: got %0d expected %0d", frame_cnt, frames_m); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic [23:0] da, db;
    int budget;
    da = 24'h123456;
    db = 24'h789012;
    rdy_mode = 0;
    report(da);
    report(db);
    budget = 200;
    @(negedge clk);
    while (frame_cnt !== 16'(frames_m + 1) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (budget == 0 || tx_data_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: valid=%b busy=%b budget=%0d expected valid=0 busy=0", tx_data_valid, busy, budget);
    end
    @(negedge clk);
    checks++;
    if (tx_data_valid !== 1'b1 || tx_data !== 8'h54) begin
      errors++; $display("FAIL b2b_second_start: valid=%b data=%h expected valid=1 data=54", tx_data_valid, tx_data);
    end
    @(posedge clk); #1;
    wait_bytes(30);
    frames_m += 2;
    checks++;
    if (rx_q.size() < 30) begin
      errors++; $display("FAIL b2b_timeout: got %0d bytes expected 30", rx_q.size());
    end else begin
      for (int i = 0; i < 30; i++) begin
        b = rx_q.pop_front();
        checks++;
        if (b !== exp_sample((i < 15) ? da : db, i % 15)) begin
          errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, b, exp_sample((i < 15) ? da : db, i % 15));
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (frame_cnt !== 16'(frames_m)) begin errors++; $display("FAIL b2b_frame_cnt: got %0d expected %0d", frame_cnt, frames_m); end
  endtask

  task automatic test_overrun();
    logic [7:0] b;
    rdy_mode = 3;
    report(24'h111111);
    report(24'h222222);
    report(24'h333333);
    checks += 2;
    if (drop_cnt !== 8'd1) begin errors++; $display("FAIL ovr_drop_cnt: got %0d expected 1", drop_cnt); end
    if (tx_data_valid !== 1'b1 || tx_data !== 8'h54) begin
      errors++; $display("FAIL ovr_stalled_first: valid=%b data=%h expected valid=1 data=54", tx_data_valid, tx_data);
    end
    rdy_mode = 0;
    wait_bytes(30);
    frames_m += 2;
    checks++;
    if (rx_q.size() < 30) begin
      errors++; $display("FAIL ovr_timeout: got %0d bytes expected 30", rx_q.size());
    end else begin
      for (int i = 0; i < 30; i++) begin
        b = rx_q.pop_front();
        checks++;
        if (b !== exp_sample((i < 15) ? 24'h111111 : 24'h333333, i % 15)) begin
          errors++; $display("FAIL ovr_byte%0d: got %h expected %h", i, b, exp_sample((i < 15) ? 24'h111111 : 24'h333333, i % 15));
        end
      end
    end
    repeat (20) @(posedge clk);
    #1;
    checks += 2;
    if (rx_q.size() != 0) begin errors++; $display("FAIL ovr_extra_bytes: got %0d expected 0", rx_q.size()); end
    if (frame_cnt !== 16'(frames_m)) begin errors++; $display("FAIL ovr_frame_cnt: got %0d expected %0d", frame_cnt, frames_m); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [23:0] d;
    for (int n = 0; n < 8; n++) begin
      d = 24'($urandom);
      rdy_mode = 2;
      report(d);
      wait_bytes(15);
      frames_m++;
      checks++;
      if (rx_q.size() < 15) begin
        errors++; $display("FAIL rnd%0d_timeout: got %0d bytes expected 15", n, rx_q.size());
      end else begin
        for (int i = 0; i < 15; i++) begin
          b = rx_q.pop_front();
          checks++;
          if (b !== exp_sample(d, i)) begin
            errors++; $display("FAIL rnd%0d_byte%0d: data=%h got %h expected %h", n, i, d, b, exp_sample(d, i));
          end
        end
      end
      rdy_mode = 0;
      repeat (3) @(posedge clk);
      #1;
    end
    checks += 2;
    if (frame_cnt !== 16'(frames_m)) begin errors++; $display("FAIL rnd_frame_cnt: got %0d expected %0d", frame_cnt, frames_m); end
    if (drop_cnt !== 8'd1) begin errors++; $display("FAIL rnd_drop_cnt: got %0d expected 1", drop_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    logic [23:0] d;
    rdy_mode = 0;
    report(24'h987654);
    wait_bytes(5);
    checks++;
    if (rx_q.size() < 5) begin errors++; $display("FAIL rstmid_timeout: got %0d bytes expected 5", rx_q.size()); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data: got %h expected 00", tx_data); end
    if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", tx_data_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_frame_cnt: got %0d expected 0", frame_cnt); end
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_drop_cnt: got %0d expected 0", drop_cnt); end
    rx_q.delete();
    div_m = 0;
    frames_m = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    d = 24'h102938;
    report(d);
    wait_bytes(15);
    frames_m++;
    checks++;
    if (rx_q.size() < 15) begin
      errors++; $display("FAIL rstmid_frame_timeout: got %0d bytes expected 15", rx_q.size());
    end else begin
      for (int i = 0; i < 15; i++) begin
        b = rx_q.pop_front();
        checks++;
        if (b !== exp_sample(d, i)) begin errors++; $display("FAIL rstmid_byte%0d: got %h expected %h", i, b, exp_sample(d, i)); end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (frame_cnt !== 16'(frames_m)) begin errors++; $display("FAIL rstmid_frame_cnt_after: got %0d expected %0d", frame_cnt, frames_m); end
  endtask

  task automatic test_timeout();
    bit r;
    logic [7:0] b;
    int budget;
    int s_cyc;
    rdy_mode = 0;
    rx_q.delete();
    e_cyc_q.delete();
    budget = 400;
    while (e_cyc_q.size() < 2 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    wait_bytes(10);
    checks++;
    if (e_cyc_q.size() < 2 || rx_q.size() < 10) begin
      errors++; $display("FAIL to_timeout: got %0d ERR starts and %0d bytes expected 2 and 10", e_cyc_q.size(), rx_q.size());
    end else begin
      checks++;
      if (e_cyc_q[1] - e_cyc_q[0] != 100) begin
        errors++; $display("FAIL to_period: got %0d cycles expected 100", e_cyc_q[1] - e_cyc_q[0]);
      end
      for (int i = 0; i < 10; i++) begin
        b = rx_q.pop_front();
        checks++;
        if (b !== exp_err(i % 5)) begin errors++; $display("FAIL to_byte%0d: got %h expected %h", i, b, exp_err(i % 5)); end
      end
      while (cyc < e_cyc_q[1] + 48) begin @(posedge clk); #1; end
      inject(24'h555555, r);
      s_cyc = cyc;
      budget = 400;
      while (e_cyc_q.size() < 3 && budget > 0) begin
        @(posedge clk); #1;
        budget--;
      end
      wait_bytes(5);
      checks++;
      if (e_cyc_q.size() < 3) begin
        errors++; $display("FAIL to_third_missing: got %0d ERR starts expected 3", e_cyc_q.size());
      end else if (e_cyc_q[2] != s_cyc + 101) begin
        errors++; $display("FAIL to_delayed: ERR start at cycle %0d expected %0d", e_cyc_q[2], s_cyc + 101);
      end
      @(posedge clk); #1;
      checks++;
      if (frame_cnt !== 16'd3) begin errors++; $display("FAIL to_frame_cnt: got %0d expected 3", frame_cnt); end
    end
  endtask

  initial begin
    test_reset();
`ifdef DHT11_ERR_REPORT_EN
    test_timeout();
`else
    test_basic();
    test_divider();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_random();
    test_reset_mid_frame();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
